// File: rtl/bird_physics_render.sv
`default_nettype none
// ============================================================================
//  Module   : bird_physics_render
//  Purpose  : Per-pixel renderer and once-per-frame bird physics for the
//             Flappy Bird display path. Consumes hc/vc/showon from the VGA
//             timing generator and produces registered 8-bit RGB.
//  Revision : 1.0  initial release
// ============================================================================
module bird_physics_render #(
    parameter int BIRD_X    = 300,
    parameter int BIRD_SIZE = 16,
    parameter int Y_START   = 232,
    parameter int Y_MAX     = 464,
    parameter int FLAP_VEL  = -8,
    parameter int GRAVITY   = 1,
    parameter int MAX_FALL  = 8
) (
    input  logic       vga_clk,
    input  logic       rst,
    input  logic [9:0] hc,
    input  logic [9:0] vc,
    input  logic       showon,
    input  logic       flap,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic [8:0] bird_y,
    output logic [1:0] state,
    output logic       dead
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FLY  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    localparam logic        [8:0]  c_y_start   = 9'(Y_START);
    localparam logic        [8:0]  c_y_max     = 9'(Y_MAX);
    localparam logic signed [10:0] c_y_max11   = 11'(Y_MAX);
    localparam logic signed [5:0]  c_flap_vel  = 6'(FLAP_VEL);
    localparam logic signed [6:0]  c_gravity   = 7'(GRAVITY);
    localparam logic signed [6:0]  c_max_fall7 = 7'(MAX_FALL);
    localparam logic signed [5:0]  c_max_fall6 = 6'(MAX_FALL);
    localparam logic        [9:0]  c_bird_x    = 10'(BIRD_X);
    localparam logic        [9:0]  c_bird_xe   = 10'(BIRD_X + BIRD_SIZE);
    localparam logic        [10:0] c_size11    = 11'(BIRD_SIZE);

    state_t             r_state;
    state_t             w_state_nx;
    logic        [8:0]  r_bird_y;
    logic        [8:0]  w_y_nx;
    logic signed [5:0]  r_vel;
    logic signed [5:0]  w_vel_nx;
    logic               r_flap_d;
    logic               r_flap_pending;

    logic               w_tick;
    logic               w_flap_edge;
    logic               w_flap_now;
    logic signed [6:0]  w_vel_grav;
    logic signed [5:0]  w_vel_sat;
    logic signed [5:0]  w_vel_new;
    logic signed [10:0] w_ny;

    // Last clock of the frame: the only cycle in which physics advances.
    assign w_tick      = (hc == 10'd799) && (vc == 10'd524);
    assign w_flap_edge = flap & ~r_flap_d;
    // An edge landing on the tick cycle itself still counts for that tick.
    assign w_flap_now  = r_flap_pending | w_flap_edge;

    assign w_vel_grav = {r_vel[5], r_vel} + c_gravity;
    assign w_vel_sat  = (w_vel_grav > c_max_fall7) ? c_max_fall6 : w_vel_grav[5:0];
    assign w_vel_new  = w_flap_now ? c_flap_vel : w_vel_sat;
    // Widened signed sum so the ceiling/ground clamps see the true value.
    assign w_ny       = $signed({2'b00, r_bird_y}) + $signed({{5{w_vel_new[5]}}, w_vel_new});

    // Flap history and pending flag; pending is consumed on every tick.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_flap_d       <= 1'b0;
            r_flap_pending <= 1'b0;
        end else begin
            r_flap_d <= flap;
            if (w_tick)
                r_flap_pending <= 1'b0;
            else if (w_flap_edge)
                r_flap_pending <= 1'b1;
        end
    end

    // Game state, position and velocity registers.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_bird_y <= c_y_start;
            r_vel    <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_bird_y <= w_y_nx;
            r_vel    <= w_vel_nx;
        end
    end

    // Next-state and physics update, evaluated only on the frame tick.
    always_comb begin
        w_state_nx = r_state;
        w_y_nx     = r_bird_y;
        w_vel_nx   = r_vel;
        if (w_tick) begin
            case (r_state)
                ST_IDLE, ST_FLY: begin
                    if (r_state == ST_IDLE && !w_flap_now) begin
                        w_y_nx   = c_y_start;
                        w_vel_nx = '0;
                    end else if (w_ny[10]) begin
                        w_y_nx     = '0;
                        w_vel_nx   = '0;
                        w_state_nx = ST_FLY;
                    end else if (w_ny >= c_y_max11) begin
                        w_y_nx     = c_y_max;
                        w_vel_nx   = '0;
                        w_state_nx = ST_DEAD;
                    end else begin
                        w_y_nx     = w_ny[8:0];
                        w_vel_nx   = w_vel_new;
                        w_state_nx = ST_FLY;
                    end
                end
                ST_DEAD: begin
                    if (w_flap_now) begin
                        w_y_nx     = c_y_start;
                        w_vel_nx   = '0;
                        w_state_nx = ST_IDLE;
                    end
                end
                default: begin
                    w_y_nx     = c_y_start;
                    w_vel_nx   = '0;
                    w_state_nx = ST_IDLE;
                end
            endcase
        end
    end

    logic [9:0]  w_x;
    logic [9:0]  w_y;
    logic [10:0] w_y11;
    logic [10:0] w_top11;
    logic        w_in_box;

    assign w_x      = hc - 10'd144;
    assign w_y      = vc - 10'd35;
    assign w_y11    = {1'b0, w_y};
    assign w_top11  = {2'b00, r_bird_y};
    assign w_in_box = (w_x >= c_bird_x) && (w_x < c_bird_xe) &&
                      (w_y11 >= w_top11) && (w_y11 < (w_top11 + c_size11));

    // Registered pixel colour: black in blanking, bird box, otherwise sky.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            vga_r <= 8'h00;
            vga_g <= 8'h00;
            vga_b <= 8'h00;
        end else if (!showon) begin
            vga_r <= 8'h00;
            vga_g <= 8'h00;
            vga_b <= 8'h00;
        end else if (w_in_box) begin
            vga_r <= 8'hFF;
            vga_g <= (r_state == ST_DEAD) ? 8'h00 : 8'hD0;
            vga_b <= 8'h00;
        end else begin
            vga_r <= 8'h70;
            vga_g <= 8'hC0;
            vga_b <= 8'hFF;
        end
    end

    assign bird_y = r_bird_y;
    assign state  = r_state;
    assign dead   = (r_state == ST_DEAD);

endmodule
`default_nettype wire

// File: tb/tb_bird_physics_render.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bird_physics_render
//  Purpose  : Directed self-checking bench for bird_physics_render. Frames
//             are shortened by driving hc/vc directly; the tick is hc=799,
//             vc=524.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bird_physics_render;

    logic       vga_clk;
    logic       rst;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       showon;
    logic       flap;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic [8:0] bird_y;
    logic [1:0] state;
    logic       dead;

    int checks   = 0;
    int failures = 0;

    bird_physics_render dut (
        .vga_clk (vga_clk),
        .rst     (rst),
        .hc      (hc),
        .vc      (vc),
        .showon  (showon),
        .flap    (flap),
        .vga_r   (vga_r),
        .vga_g   (vga_g),
        .vga_b   (vga_b),
        .bird_y  (bird_y),
        .state   (state),
        .dead    (dead)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it in, settle 1 time unit past the edge.
    task automatic drv(input logic [9:0] h, input logic [9:0] v, input logic s, input logic f);
        hc = h; vc = v; showon = s; flap = f;
        @(posedge vga_clk);
        #1;
    endtask

    // One shortened frame: optional flap pulse, then the tick cycle.
    task automatic frame(input bit do_flap);
        if (do_flap) begin
            drv(10'd0, 10'd0, 1'b0, 1'b1);
            drv(10'd0, 10'd0, 1'b0, 1'b0);
        end
        drv(10'd799, 10'd524, 1'b0, 1'b0);
        drv(10'd0, 10'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; hc = '0; vc = '0; showon = 1'b0; flap = 1'b0;
        drv(10'd0, 10'd0, 1'b0, 1'b0);
        drv(10'd0, 10'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Make RGB non-zero, then hit reset mid-frame between edges.
        drv(10'd400, 10'd100, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rst_rgb",    {8'h0, vga_r, vga_g, vga_b}, 32'h0);
        chk("rst_state",  {30'h0, state}, 32'd0);
        chk("rst_y",      {23'h0, bird_y}, 32'd232);
        chk("rst_dead",   {31'h0, dead}, 32'd0);
        @(negedge vga_clk);
        rst = 1'b0;

        // Rendering: bird box edges, sky, blanking.
        drv(10'd444, 10'd267, 1'b1, 1'b0);
        chk("px_bird_tl", {8'h0, vga_r, vga_g, vga_b}, 32'hFFD000);
        drv(10'd459, 10'd282, 1'b1, 1'b0);
        chk("px_bird_br", {8'h0, vga_r, vga_g, vga_b}, 32'hFFD000);
        drv(10'd460, 10'd267, 1'b1, 1'b0);
        chk("px_right_out", {8'h0, vga_r, vga_g, vga_b}, 32'h70C0FF);
        drv(10'd443, 10'd267, 1'b1, 1'b0);
        chk("px_left_out", {8'h0, vga_r, vga_g, vga_b}, 32'h70C0FF);
        drv(10'd444, 10'd283, 1'b1, 1'b0);
        chk("px_below_out", {8'h0, vga_r, vga_g, vga_b}, 32'h70C0FF);
        drv(10'd144, 10'd35, 1'b1, 1'b0);
        chk("px_sky_00", {8'h0, vga_r, vga_g, vga_b}, 32'h70C0FF);
        drv(10'd444, 10'd267, 1'b0, 1'b0);
        chk("px_blank", {8'h0, vga_r, vga_g, vga_b}, 32'h0);

        // Idle tick without a flap keeps the bird parked.
        frame(1'b0);
        chk("idle_y", {23'h0, bird_y}, 32'd232);
        chk("idle_state", {30'h0, state}, 32'd0);

        // Single flap, then gravity decelerates the climb.
        frame(1'b1);
        chk("flap_t1_y", {23'h0, bird_y}, 32'd224);
        chk("flap_t1_state", {30'h0, state}, 32'd1);
        frame(1'b0);
        chk("flap_t2_y", {23'h0, bird_y}, 32'd217);
        frame(1'b0);
        chk("flap_t3_y", {23'h0, bird_y}, 32'd211);
        frame(1'b0);
        chk("flap_t4_y", {23'h0, bird_y}, 32'd206);
        chk("flap_t4_state", {30'h0, state}, 32'd1);

        // Free fall until ground contact at tick 46.
        for (int t = 5; t <= 45; t++) begin
            frame(1'b0);
            if (t == 9)  chk("fall_apex_y", {23'h0, bird_y}, 32'd196);
            if (t == 17) chk("fall_t17_y",  {23'h0, bird_y}, 32'd232);
        end
        chk("fall_t45_y", {23'h0, bird_y}, 32'd456);
        chk("fall_t45_state", {30'h0, state}, 32'd1);
        frame(1'b0);
        chk("ground_y", {23'h0, bird_y}, 32'd464);
        chk("ground_state", {30'h0, state}, 32'd2);
        chk("ground_dead", {31'h0, dead}, 32'd1);
        drv(10'd444, 10'd499, 1'b1, 1'b0);
        chk("px_dead_bird", {8'h0, vga_r, vga_g, vga_b}, 32'hFF0000);
        frame(1'b0);
        chk("dead_frozen_y", {23'h0, bird_y}, 32'd464);
        chk("dead_frozen_state", {30'h0, state}, 32'd2);

        // Respawn: flap while dead returns to IDLE without starting flight.
        frame(1'b1);
        chk("respawn_state", {30'h0, state}, 32'd0);
        chk("respawn_y", {23'h0, bird_y}, 32'd232);
        chk("respawn_dead", {31'h0, dead}, 32'd0);
        frame(1'b0);
        chk("respawn_hold_state", {30'h0, state}, 32'd0);

        // Flap edge arriving exactly on the tick cycle.
        drv(10'd0, 10'd0, 1'b0, 1'b0);
        drv(10'd799, 10'd524, 1'b0, 1'b1);
        drv(10'd0, 10'd0, 1'b0, 1'b0);
        chk("tickflap_state", {30'h0, state}, 32'd1);
        chk("tickflap_y", {23'h0, bird_y}, 32'd224);

        // Two edges within one frame give a single -8 step.
        drv(10'd0, 10'd0, 1'b0, 1'b1);
        drv(10'd0, 10'd0, 1'b0, 1'b0);
        drv(10'd0, 10'd0, 1'b0, 1'b1);
        drv(10'd0, 10'd0, 1'b0, 1'b0);
        drv(10'd799, 10'd524, 1'b0, 1'b0);
        drv(10'd0, 10'd0, 1'b0, 1'b0);
        chk("dblflap_y", {23'h0, bird_y}, 32'd216);

        // Climb to y=4: 23 flaps to 32, then 7 coasting ticks (-7..-1).
        for (int i = 0; i < 23; i++) frame(1'b1);
        chk("climb_y32", {23'h0, bird_y}, 32'd32);
        for (int i = 0; i < 7; i++) frame(1'b0);
        chk("climb_y4", {23'h0, bird_y}, 32'd4);

        // Ceiling clamp: 4-8 < 0 pins at 0, stays in FLY.
        frame(1'b1);
        chk("ceil1_y", {23'h0, bird_y}, 32'd0);
        chk("ceil1_state", {30'h0, state}, 32'd1);
        frame(1'b1);
        chk("ceil2_y", {23'h0, bird_y}, 32'd0);
        chk("ceil2_state", {30'h0, state}, 32'd1);
        frame(1'b0);
        chk("ceil_release_y", {23'h0, bird_y}, 32'd1);

        // Reset mid-flight.
        #2 rst = 1'b1;
        #1;
        chk("rst2_y", {23'h0, bird_y}, 32'd232);
        chk("rst2_state", {30'h0, state}, 32'd0);
        @(negedge vga_clk);
        rst = 1'b0;
        frame(1'b0);
        chk("rst2_idle_y", {23'h0, bird_y}, 32'd232);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bird_physics_render.md
# bird_physics_render

Per-pixel renderer and bird physics engine for the Flappy Bird display path. Sits directly downstream of the VGA timing generator and consumes its `hc`, `vc` and `showon` outputs. Once per frame it updates the bird's vertical position and velocity from a flap button, following a three-state game FSM. Each pixel clock it produces registered 8-bit RGB for the DAC.

## Interface
Parameters:
- `BIRD_X`, 300: left edge of bird box, active-area x coordinate
- `BIRD_SIZE`, 16: bird box width and height in pixels
- `Y_START`, 232: bird top-edge y at reset and on respawn
- `Y_MAX`, 464: ground contact y, equal to 480 − `BIRD_SIZE`
- `FLAP_VEL`, −8: velocity loaded on flap, signed, pixels per frame
- `GRAVITY`, 1: velocity increment per frame
- `MAX_FALL`, 8: velocity saturation limit

Ports (clock and reset first):
- `vga_clk`  in  1  pixel clock, 25 MHz
- `rst`  in  1  asynchronous, active-high reset
- `hc`  in  10  horizontal counter, 0..799, from timing generator
- `vc`  in  10  vertical counter, 0..524, from timing generator
- `showon`  in  1  active-video flag from timing generator
- `flap`  in  1  flap button, already synchronous to `vga_clk`, active high
- `vga_r`, `vga_g`, `vga_b`  out  8 each  registered pixel colour
- `bird_y`  out  9  current bird top-edge y, 0..`Y_MAX`
- `state`  out  2  game state: 0 = IDLE, 1 = FLY, 2 = DEAD
- `dead`  out  1  high while `state` is DEAD

## Operation
- **Active coordinates:** x = hc − 144, y = vc − 35. Both are used only when `showon` is 1.
- **Frame tick:** one-cycle pulse when hc==799 and vc==524. This is the last clock of the frame. All physics updates happen only on the tick, so `bird_y` is stable for a whole frame and there is no tearing.
- **Flap capture:**
  - A rising edge of `flap` is detected against a registered copy of `flap`.
  - The edge sets `flap_pending`.
  - `flap_pending` is cleared on the tick.
  - An edge arriving in the tick cycle itself is counted for that tick.
  - Multiple edges within one frame count as a single flap.
- **Internal state:** `vel` is 6-bit signed. The next-y intermediate `ny` is 11-bit signed.
- **State IDLE:**
  - `bird_y` = `Y_START`, `vel` = 0.
  - Tick with flap pending: `vel` ← `FLAP_VEL`, `ny` = y + `FLAP_VEL`, go to FLY.
- **State FLY, on each tick:**
  - `vel'` = `FLAP_VEL` if flap pending, else min(`vel` + `GRAVITY`, `MAX_FALL`).
  - `ny` = `bird_y` + `vel'`.
  - If `ny` < 0: `bird_y` ← 0 and `vel` ← 0 (ceiling clamp; stays in FLY).
  - Else if `ny` ≥ `Y_MAX`: `bird_y` ← `Y_MAX`, `vel` ← 0, go to DEAD.
  - Otherwise: `bird_y` ← `ny`, `vel` ← `vel'`.
- **State DEAD:**
  - Position is frozen.
  - Tick with flap pending: `bird_y` ← `Y_START`, `vel` ← 0, go to IDLE. The flap is consumed and does not start flight.
- **State encoding 3:** illegal; recovers to IDLE on the next tick.
- **Pixel colour selection:**
  - `showon` = 0: RGB = 00,00,00.
  - Pixel inside the bird box, i.e. `BIRD_X` ≤ x < `BIRD_X` + `BIRD_SIZE` and `bird_y` ≤ y < `bird_y` + `BIRD_SIZE`: FF,D0,00 when alive, FF,00,00 in DEAD.
  - Any other active pixel: sky, 70,C0,FF.

## Timing
- **Reset values:**
  - `vga_r`/`vga_g`/`vga_b` = 0, `state` = IDLE, `dead` = 0, `bird_y` = `Y_START`.
  - Internal: `vel` = 0, `flap_pending` = 0, flap history = 0.
  - Reset takes effect immediately, mid-frame or mid-flight, and output is black until the first post-reset clock edge.
- **Render latency:** RGB for a given (hc, vc, showon) appears on the clock edge after those inputs are sampled, i.e. one cycle. The top level delays hs/vs by one register to match.
- **Physics latency:** `bird_y`, `state` and `dead` change on the clock edge that ends the tick cycle. The new values are visible from hc=0, vc=0 of the next frame.
- **Arithmetic:** all velocity and position arithmetic is signed with no wrap; clamping happens before the result is written to the 9-bit `bird_y`.

## Test plan
- **Reset:** assert `rst` mid-frame, release → `bird_y` = 232, `state` = 0, RGB = 0; at pixel (x=300, y=232) RGB = FF,D0,00; at (x=0, y=0) RGB = 70,C0,FF; with `showon` = 0, RGB = 0.
- **Single flap:** one `flap` pulse in frame 0 → after ticks 1..4, `bird_y` = 224, 217, 211, 206 and `state` = 1.
- **Free fall:** no further flaps after the first → `vel` saturates at 8, the bird reaches `bird_y` = 464, `state` = 2, `dead` = 1, and the bird box renders FF,00,00.
- **Ceiling clamp:** flap on every frame from `bird_y` = 4 → `bird_y` = 0 and stays 0; `state` remains FLY.
- **Tick-cycle flap and double flap:** a flap edge exactly on the tick cycle is applied on that tick; two edges within one frame produce one −8 step.
- **Respawn:** flap while DEAD → after the next tick `state` = IDLE and `bird_y` = 232; a further flap is required to enter FLY.
